// File: rtl/seg_display.sv
// Memory-mapped 8-digit multiplexed hex display driver.
// Holds the VALUE/CTRL registers, a scan prescaler, and registered active-low digit/segment outputs.
`ifndef PERI_ADDR_DIG
`define PERI_ADDR_DIG 32'h4000_0100
`endif

module seg_display #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter logic [31:0] BASE_ADDR = `PERI_ADDR_DIG
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [7:0]  an_o,
    output logic [7:0]  seg_o
);
    localparam logic [19:0] PRESC_MAX = 20'(SCAN_DIV - 1);

    logic [31:0] value_q, value_d;
    logic        en_q, en_d;
    logic        blank_q, blank_d;
    logic [7:0]  mask_q, mask_d;
    logic [19:0] presc_q, presc_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  an_q, an_d;
    logic [7:0]  seg_q, seg_d;

    logic       hit, sel_value, sel_ctrl;
    logic [3:0] nibble;
    logic       lit;
    logic       unused_bits;

    assign hit       = (addr_i[31:4] == BASE_ADDR[31:4]);
    assign sel_value = hit && (addr_i[3:2] == 2'd0);
    assign sel_ctrl  = hit && (addr_i[3:2] == 2'd1);

    assign unused_bits = ^{addr_i[1:0], data_i[31:16], data_i[7:2]};

    // zero_above[i]: every nibble from digit i upward is zero, i.e. digit i is a leading zero.
    logic [7:0] zero_above;
    assign zero_above[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_zero
            assign zero_above[gi] = (value_q[31:4*gi] == '0);
        end
    endgenerate

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        value_d = value_q;
        en_d    = en_q;
        blank_d = blank_q;
        mask_d  = mask_q;
        if (we_i && sel_value) begin
            value_d = data_i;
        end
        if (we_i && sel_ctrl) begin
            en_d    = data_i[0];
            blank_d = data_i[1];
            mask_d  = data_i[15:8];
        end

        rdata_d = '0;
        if (sel_value) begin
            rdata_d = value_q;
        end else if (sel_ctrl) begin
            rdata_d = {16'h0, mask_q, 6'h0, blank_q, en_q};
        end

        presc_d = presc_q;
        idx_d   = idx_q;
        if (!en_q) begin
            presc_d = '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            idx_d   = idx_q + 3'd1;
        end else begin
            presc_d = presc_q + 20'd1;
        end

        nibble = value_q[{idx_q, 2'b00} +: 4];
        lit    = en_q && mask_q[idx_q] && !(blank_q && zero_above[idx_q]);
        an_d   = lit ? ~(8'b1 << idx_q) : 8'hFF;
        seg_d  = lit ? {1'b1, hex7(nibble)} : 8'hFF;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            value_q <= '0;
            en_q    <= 1'b1;
            blank_q <= 1'b0;
            mask_q  <= 8'hFF;
            presc_q <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            an_q    <= 8'hFF;
            seg_q   <= 8'hFF;
        end else begin
            value_q <= value_d;
            en_q    <= en_d;
            blank_q <= blank_d;
            mask_q  <= mask_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign data_o = rdata_q;
    assign an_o   = an_q;
    assign seg_o  = seg_q;
endmodule
